// File: rtl/mole_pkg.sv
// ============================================================================
//  Module   : mole_pkg
//  Purpose  : Shared definitions for the whack-a-mole scheduler: state
//             encoding, LFSR polynomial, miss counter width and the LFSR
//             step function.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mole_pkg;

    // State codes as seen on state_o
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GAP  = 2'b01;
    localparam logic [1:0] ST_UP   = 2'b10;
    localparam logic [1:0] ST_OVER = 2'b11;

    // 16-bit Galois LFSR, right-shifting, feedback mask applied when bit 0 is 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Width of the miss counter (MAX_MISSES is 1..15)
    localparam int MISS_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_GAP  = ST_GAP,
        S_UP   = ST_UP,
        S_OVER = ST_OVER
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mole_scheduler_if.sv
// ============================================================================
//  Module   : mole_scheduler_if
//  Purpose  : Game-side bus of the mole scheduler.
//  Ports    : start_i, whacked_i          -> into the scheduler
//             mole_o, score_o, misses_o,
//             state_o, hit_pulse_o,
//             game_over_o                 <- out of the scheduler
//  Modports : master - environment (switch wiring / whack handler / display)
//             slave  - the scheduler itself
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mole_scheduler_if #(
    parameter int N_HOLES = 16,
    parameter int SCORE_W = 8
) ();

    logic                        start_i;
    logic                        whacked_i;
    logic [N_HOLES-1:0]          mole_o;
    logic [SCORE_W-1:0]          score_o;
    logic [mole_pkg::MISS_W-1:0] misses_o;
    logic [1:0]                  state_o;
    logic                        hit_pulse_o;
    logic                        game_over_o;

    modport master (
        output start_i,
        output whacked_i,
        input  mole_o,
        input  score_o,
        input  misses_o,
        input  state_o,
        input  hit_pulse_o,
        input  game_over_o
    );

    modport slave (
        input  start_i,
        input  whacked_i,
        output mole_o,
        output score_o,
        output misses_o,
        output state_o,
        output hit_pulse_o,
        output game_over_o
    );

endinterface

`default_nettype wire

// File: rtl/mole_lfsr.sv
// ============================================================================
//  Module   : mole_lfsr
//  Purpose  : Free-running 16-bit Galois LFSR (taps 0xB400). Steps on every
//             clock once out of reset; reset reloads the seed.
//  Ports    : clk_i   in   clock
//             reset_i in   synchronous reset, active-low
//             seed    in   16-bit reset value (must be nonzero)
//             lfsr_o  out  current LFSR contents
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mole_lfsr
    import mole_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] seed,
    output logic [15:0] lfsr_o
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_lfsr <= seed;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign lfsr_o = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/mole_scheduler.sv
// ============================================================================
//  Module   : mole_scheduler
//  Purpose  : Whack-a-mole game sequencer. Chooses when and where a mole
//             appears, drives a one-hot mole bus, credits hits from the
//             whack handler, counts misses and ends the game after
//             MAX_MISSES misses.
//  Ports    : clk_i    in  system clock
//             reset_i  in  synchronous reset, active-low
//             bus      mole_scheduler_if.slave
//                      start_i/whacked_i in; mole_o, score_o, misses_o,
//                      state_o, hit_pulse_o, game_over_o out
//  Options  : MOLE_SCHEDULER_SPEEDUP_EN - shrink the up-window by
//             SPEEDUP_STEP per 4 points, floored at MIN_UP_CYCLES.
//             Undefined: fixed window of UP_CYCLES.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mole_scheduler
    import mole_pkg::*;
#(
    parameter int          N_HOLES       = 16,
    parameter int          UP_CYCLES     = 50_000_000,
    parameter int          GAP_CYCLES    = 25_000_000,
    parameter int          MAX_MISSES    = 3,
    parameter int          SCORE_W       = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          SPEEDUP_STEP  = 1_000_000,
    parameter int          MIN_UP_CYCLES = 10_000_000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    mole_scheduler_if.slave  bus
);

    localparam int c_hole_w  = $clog2(N_HOLES);
    localparam int c_tmr_max = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;

    localparam logic [c_tmr_w-1:0] c_gap_load = c_tmr_w'(GAP_CYCLES - 1);
    localparam logic [MISS_W-1:0]  c_max_miss = MISS_W'(MAX_MISSES);
    localparam logic [SCORE_W-1:0] c_score_max = {SCORE_W{1'b1}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_tmr_w-1:0]   r_timer;
    logic [c_tmr_w-1:0]   w_up_load;
    logic [SCORE_W-1:0]   r_score;
    logic [MISS_W-1:0]    r_misses;
    logic [MISS_W-1:0]    w_misses_inc;
    logic [N_HOLES-1:0]   r_mole;
    logic [c_hole_w-1:0]  r_prev_hole;
    logic [c_hole_w-1:0]  w_lfsr_hole;
    logic [c_hole_w-1:0]  w_hole;
    logic                 r_hit_pulse;
    logic [15:0]          w_lfsr;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_spawn;
    logic                 w_new_game;
    logic                 w_gap_entry;
    logic                 w_unused_lfsr;

    // ------------------------------------------------------------------
    // Random source; runs in every state so the spawn sequence depends on
    // when the player presses start.
    // ------------------------------------------------------------------
    mole_lfsr u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .seed    (LFSR_SEED),
        .lfsr_o  (w_lfsr)
    );

    // Only the low bits pick the hole
    assign w_unused_lfsr = ^w_lfsr[15:c_hole_w];

    // Avoid showing the same hole twice in a row: bump to the next hole
    assign w_lfsr_hole = w_lfsr[c_hole_w-1:0];
    assign w_hole      = (w_lfsr_hole == r_prev_hole) ? (w_lfsr_hole + c_hole_w'(1))
                                                      : w_lfsr_hole;

    // ------------------------------------------------------------------
    // Up-window length, sampled when the mole is spawned
    // ------------------------------------------------------------------
`ifdef MOLE_SCHEDULER_SPEEDUP_EN
    localparam logic [63:0] c_min_up = 64'(MIN_UP_CYCLES);
    localparam logic [63:0] c_up     = 64'(UP_CYCLES);
    // Largest reduction that still keeps the window at or above the floor
    localparam logic [63:0] c_room   = (UP_CYCLES > MIN_UP_CYCLES)
                                       ? 64'(UP_CYCLES - MIN_UP_CYCLES) : 64'd0;

    logic [63:0] w_cut;
    logic [63:0] w_window;

    always_comb begin
        w_cut = 64'(r_score >> 2) * 64'(SPEEDUP_STEP);
        if (w_cut >= c_room) begin
            w_window = c_min_up;
        end else begin
            w_window = c_up - w_cut;
        end
    end

    assign w_up_load = c_tmr_w'(w_window - 64'd1);
`else
    // Speed-up knobs have no effect in the fixed-window build
    localparam int c_unused_speedup = SPEEDUP_STEP + MIN_UP_CYCLES;

    assign w_up_load = c_tmr_w'(UP_CYCLES - 1);
`endif

    // ------------------------------------------------------------------
    // Game FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_misses_inc = r_misses + MISS_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_spawn     = 1'b0;
        w_new_game  = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.start_i) begin
                    w_new_game  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_timer == '0) begin
                    w_spawn     = 1'b1;
                    w_state_nxt = S_UP;
                end
            end
            S_UP: begin
                // A whack on the last up cycle still counts as a hit
                if (bus.whacked_i) begin
                    w_hit       = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (r_timer == '0) begin
                    w_miss      = 1'b1;
                    w_state_nxt = (w_misses_inc == c_max_miss) ? S_OVER : S_GAP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_gap_entry = (w_state_nxt == S_GAP) && (r_state != S_GAP);

    // ------------------------------------------------------------------
    // Timer, score, misses, mole bus
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_timer     <= '0;
            r_score     <= '0;
            r_misses    <= '0;
            r_mole      <= '0;
            r_prev_hole <= '0;
            r_hit_pulse <= 1'b0;
        end else begin
            r_hit_pulse <= w_hit;

            // Timer is loaded with length-1 so a phase lasts exactly length cycles
            if (w_gap_entry) begin
                r_timer <= c_gap_load;
            end else if (w_spawn) begin
                r_timer <= w_up_load;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - c_tmr_w'(1);
            end

            if (w_new_game) begin
                r_score  <= '0;
                r_misses <= '0;
            end else begin
                if (w_hit && (r_score != c_score_max)) begin
                    r_score <= r_score + SCORE_W'(1);
                end
                if (w_miss) begin
                    r_misses <= w_misses_inc;
                end
            end

            if (w_spawn) begin
                r_prev_hole <= w_hole;
                r_mole      <= {{(N_HOLES-1){1'b0}}, 1'b1} << w_hole;
            end else if (w_hit || w_miss) begin
                r_mole      <= '0;
            end
        end
    end

    assign bus.mole_o      = r_mole;
    assign bus.score_o     = r_score;
    assign bus.misses_o    = r_misses;
    assign bus.state_o     = r_state;
    assign bus.hit_pulse_o = r_hit_pulse;
    assign bus.game_over_o = (r_state == S_OVER);

endmodule

`default_nettype wire

// File: tb/tb_mole_scheduler.sv
// ============================================================================
//  Module   : tb_mole_scheduler
//  Purpose  : Self-checking bench for mole_scheduler with a cycle-level
//             behavioural game model and randomized play.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mole_scheduler;

    localparam int N_HOLES       = 16;
    localparam int UP_CYCLES     = 8;
    localparam int GAP_CYCLES    = 4;
    localparam int MAX_MISSES    = 3;
    localparam int SCORE_W       = 8;
    localparam int SCORE_MAX     = 255;
    localparam int SPEEDUP_STEP  = 1;
    localparam int MIN_UP_CYCLES = 4;
    localparam int SEED          = 'hACE1;
`ifdef MOLE_SCHEDULER_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_GAP  = 1;
    localparam int M_UP   = 2;
    localparam int M_OVER = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mole_scheduler_if #(.N_HOLES(N_HOLES), .SCORE_W(SCORE_W)) bus ();

    mole_scheduler #(
        .N_HOLES       (N_HOLES),
        .UP_CYCLES     (UP_CYCLES),
        .GAP_CYCLES    (GAP_CYCLES),
        .MAX_MISSES    (MAX_MISSES),
        .SCORE_W       (SCORE_W),
        .LFSR_SEED     (16'hACE1),
        .SPEEDUP_STEP  (SPEEDUP_STEP),
        .MIN_UP_CYCLES (MIN_UP_CYCLES)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural game model: phase plus cycles remaining in that phase
    int          m_state  = M_IDLE;
    int          m_left   = 0;
    int          m_score  = 0;
    int          m_misses = 0;
    int          m_hole   = -1;
    int          m_prev   = 0;
    int          m_hit    = 0;
    int unsigned m_lfsr   = SEED;

    int                 spawns     = 0;
    logic [N_HOLES-1:0] last_spawn = 16'h0001;
    logic [N_HOLES-1:0] prev_mole  = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_window(input int score);
        int w;
        if (!SPEEDUP) return UP_CYCLES;
        w = UP_CYCLES - (score / 4) * SPEEDUP_STEP;
        return (w < MIN_UP_CYCLES) ? MIN_UP_CYCLES : w;
    endfunction

    task automatic model_step(input bit rn, input bit st, input bit wh);
        int unsigned cur;
        if (!rn) begin
            m_state = M_IDLE; m_left = 0; m_score = 0; m_misses = 0;
            m_hole = -1; m_prev = 0; m_hit = 0; m_lfsr = SEED;
            return;
        end
        cur    = m_lfsr;
        m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 32'h0000B400) : (m_lfsr >> 1);
        m_hit  = 0;
        case (m_state)
            M_IDLE, M_OVER: begin
                if (st) begin
                    m_score = 0; m_misses = 0; m_state = M_GAP; m_left = GAP_CYCLES;
                end
            end
            M_GAP: begin
                m_left--;
                if (m_left == 0) begin
                    m_hole = int'(cur % N_HOLES);
                    if (m_hole == m_prev) m_hole = (m_hole + 1) % N_HOLES;
                    m_prev  = m_hole;
                    m_state = M_UP;
                    m_left  = model_window(m_score);
                end
            end
            M_UP: begin
                if (wh) begin
                    if (m_score < SCORE_MAX) m_score++;
                    m_hit = 1; m_hole = -1; m_state = M_GAP; m_left = GAP_CYCLES;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_misses++;
                        m_hole  = -1;
                        m_state = (m_misses == MAX_MISSES) ? M_OVER : M_GAP;
                        m_left  = GAP_CYCLES;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it
    task automatic step(input bit rn, input bit st, input bit wh);
        logic [N_HOLES-1:0] exp_mole;
        rst_n         = rn;
        bus.start_i   = st;
        bus.whacked_i = wh;
        @(posedge clk);
        model_step(rn, st, wh);
        #1;
        exp_mole = (m_hole >= 0) ? (N_HOLES'(1) << m_hole) : '0;
        check_eq("mole",      bus.mole_o,      exp_mole);
        check_eq("score",     bus.score_o,     m_score);
        check_eq("misses",    bus.misses_o,    m_misses);
        check_eq("state",     bus.state_o,     m_state);
        check_eq("hit_pulse", bus.hit_pulse_o, m_hit);
        check_eq("game_over", bus.game_over_o, (m_state == M_OVER));
        if (!rn) begin
            last_spawn = 16'h0001;
        end else if (bus.mole_o != '0 && prev_mole == '0) begin
            spawns++;
            check_eq("onehot",   $onehot(bus.mole_o), 1);
            check_eq("norepeat", (bus.mole_o != last_spawn), 1);
            last_spawn = bus.mole_o;
        end
        prev_mole = bus.mole_o;
    endtask

    // Step from GAP until the model is in UP; n = cycles spent
    task automatic run_until_up(output int n);
        n = 0;
        while (m_state != M_UP && n < 100) begin
            step(1'b1, ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0));
            n++;
        end
        if (m_state != M_UP) check_eq("up_timeout", m_state, M_UP);
    endtask

    // Let the current mole expire; count the cycles it was visible
    task automatic let_miss(input int exp_len);
        int cnt = 0;
        int n   = 0;
        while (m_state == M_UP && n < 100) begin
            if (bus.mole_o != '0) cnt++;
            step(1'b1, ($urandom_range(0, 1) != 0), 1'b0);
            n++;
        end
        check_eq("up_len", cnt, exp_len);
    endtask

    task automatic hit_n(input int count);
        int n;
        repeat (count) begin
            run_until_up(n);
            step(1'b1, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int s0;

        rst_n = 1'b0; bus.start_i = 1'b0; bus.whacked_i = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_eq("rst_state", bus.state_o, 0);
        check_eq("rst_mole",  bus.mole_o,  0);

        // IDLE ignores whacks
        repeat (3) step(1'b1, 1'b0, 1'b1);
        check_eq("idle_hold", bus.state_o, M_IDLE);

        // Full unwhacked game
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= MAX_MISSES; i++) begin
            run_until_up(n);
            check_eq("gap_len", n, GAP_CYCLES);
            let_miss(UP_CYCLES);
            check_eq("miss_step", bus.misses_o, i);
        end
        check_eq("over_flag", bus.game_over_o, 1);
        check_eq("over_mole", bus.mole_o, 0);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        check_eq("over_hold", bus.misses_o, MAX_MISSES);

        // Hit on the third up cycle
        step(1'b1, 1'b1, 1'b0);
        check_eq("restart_clear", bus.misses_o, 0);
        run_until_up(n);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_eq("hit_pulse_on", bus.hit_pulse_o, 1);
        check_eq("hit_score",    bus.score_o, 1);
        check_eq("hit_mole",     bus.mole_o, 0);
        check_eq("hit_state",    bus.state_o, M_GAP);
        step(1'b1, 1'b0, 1'b0);
        check_eq("hit_pulse_off", bus.hit_pulse_o, 0);
        run_until_up(n);
        check_eq("gap_after_hit", n, GAP_CYCLES - 1);

        // Hit on the final up cycle
        repeat (UP_CYCLES - 1) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_eq("last_hit_score",  bus.score_o, 2);
        check_eq("last_hit_misses", bus.misses_o, 0);
        check_eq("last_hit_state",  bus.state_o, M_GAP);

        // Window length versus score
        hit_n(6);
        check_eq("score_8", bus.score_o, 8);
        run_until_up(n);
        let_miss(SPEEDUP ? 6 : UP_CYCLES);
        hit_n(12);
        check_eq("score_20", bus.score_o, 20);
        run_until_up(n);
        let_miss(SPEEDUP ? 4 : UP_CYCLES);
        hit_n(4);
        run_until_up(n);
        let_miss(SPEEDUP ? 4 : UP_CYCLES);
        check_eq("speed_over", bus.game_over_o, 1);

        // Reset in the middle of UP
        step(1'b1, 1'b1, 1'b0);
        hit_n(1);
        run_until_up(n);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_eq("midrst_mole",   bus.mole_o, 0);
        check_eq("midrst_score",  bus.score_o, 0);
        check_eq("midrst_misses", bus.misses_o, 0);
        check_eq("midrst_state",  bus.state_o, M_IDLE);

        // 300 consecutive hits at random points of the window
        step(1'b1, 1'b1, 1'b0);
        repeat (300) begin
            run_until_up(n);
            k = $urandom_range(0, m_left - 1);
            repeat (k) step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b1);
        end
        check_eq("score_sat",  bus.score_o, SCORE_MAX);
        check_eq("sat_misses", bus.misses_o, 0);

        // Random play for at least 1000 further spawns
        s0 = spawns;
        for (int c = 0; c < 60000 && (spawns - s0) < 1000; c++) begin
            step(($urandom_range(0, 1999) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        check_eq("spawn_count", ((spawns - s0) >= 1000), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
